// File: rtl/menu_pkg.sv
// Shared types, glyph codes and message lookup for the menu/display controller.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package menu_pkg;

  typedef enum logic [1:0] {MAIN, PLAY, OVER} state_t;

  localparam logic [6:0] GLY_P     = 7'h73;
  localparam logic [6:0] GLY_R     = 7'h50;
  localparam logic [6:0] GLY_E     = 7'h79;
  localparam logic [6:0] GLY_S     = 7'h6D;
  localparam logic [6:0] GLY_N     = 7'h54;
  localparam logic [6:0] GLY_D     = 7'h5E;
  localparam logic [6:0] GLY_BLANK = 7'h00;

  localparam logic [6:0] GLY_DIGIT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // MAIN shows "PrESS nn" (nn = start key number, 1-based); OVER shows "End".
  function automatic logic [6:0] msg_glyph(input state_t st, input logic [4:0] idx,
                                           input int start_key);
    int num;
    num = start_key + 1;
    msg_glyph = GLY_BLANK;
    if (st == MAIN) begin
      case (idx)
        5'd0:    msg_glyph = GLY_P;
        5'd1:    msg_glyph = GLY_R;
        5'd2:    msg_glyph = GLY_E;
        5'd3:    msg_glyph = GLY_S;
        5'd4:    msg_glyph = GLY_S;
        5'd6:    msg_glyph = GLY_DIGIT[4'(num / 10)];
        5'd7:    msg_glyph = GLY_DIGIT[4'(num % 10)];
        default: msg_glyph = GLY_BLANK;
      endcase
    end else if (st == OVER) begin
      case (idx)
        5'd0:    msg_glyph = GLY_E;
        5'd1:    msg_glyph = GLY_N;
        5'd2:    msg_glyph = GLY_D;
        default: msg_glyph = GLY_BLANK;
      endcase
    end
  endfunction

endpackage

// File: rtl/menu_display_ctrl_if.sv
// Keypad, game-core and 7-segment signals of the menu/display controller.
// The controller takes the slave side; the board/game side is the master.
interface menu_display_ctrl_if #(
  parameter int N_DIGITS = 8,
  parameter int KEY_W    = 12
);
  logic [KEY_W-1:0]      key_data;
  logic                  game_over;
  logic [7*N_DIGITS-1:0] disp_data;
  logic                  is_main;
  logic                  play_start;
  logic [6:0]            seg_txt;
  logic [N_DIGITS-1:0]   seg_com;

  modport master (output key_data, game_over, disp_data,
                  input  is_main, play_start, seg_txt, seg_com);
  modport slave  (input  key_data, game_over, disp_data,
                  output is_main, play_start, seg_txt, seg_com);
endinterface

// File: rtl/tick_div.sv
// Free-running divider: one-clk tick pulse every CLK_DIV clocks.
module tick_div #(
  parameter int CLK_DIV = 25000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/menu_display_ctrl.sv
// Menu/mode controller: MAIN/PLAY/OVER FSM plus scan-multiplexed 7-segment drive.
// Display and key sampling advance on scan ticks; game_over is acted on every clk.
module menu_display_ctrl
  import menu_pkg::*;
#(
  parameter int CLK_DIV     = 25000,
  parameter int N_DIGITS    = 8,
  parameter int KEY_W       = 12,
  parameter int START_KEY   = 0,
  parameter int BLINK_TICKS = 4000,
  parameter int OVER_TICKS  = 40000
) (
  input logic               clk,
  input logic               rst,
  menu_display_ctrl_if.slave bus
);
  localparam int SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BL_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int TO_W  = (OVER_TICKS > 1) ? $clog2(OVER_TICKS) : 1;
  localparam logic [KEY_W-1:0] START_HOT = KEY_W'(1) << START_KEY;

  logic                tick;
  state_t              state;
  logic [SEL_W-1:0]    sel;
  logic [KEY_W-1:0]    key_prev;
  logic [BL_W-1:0]     blink_cnt;
  logic                blink_off;
  logic [TO_W-1:0]     to_cnt;
  logic [6:0]          digit_gly [N_DIGITS];
  logic [6:0]          glyph;
  logic [N_DIGITS-1:0] com_next;
  logic                press;
  logic                timeout;

  tick_div #(.CLK_DIV(CLK_DIV)) u_div (.clk(clk), .rst(rst), .tick(tick));

  always_comb begin
    for (int d = 0; d < N_DIGITS; d++) digit_gly[d] = bus.disp_data[7*d +: 7];
  end

  // key_prev resets to all ones, which can never be a real predecessor of a
  // press, so a key held through reset is not seen as a fresh press.
  always_comb begin
    press    = tick && (bus.key_data == START_HOT) && (key_prev != START_HOT)
               && (key_prev != '1);
    timeout  = tick && (OVER_TICKS != 0) && (to_cnt == TO_W'(OVER_TICKS - 1));
    com_next = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << (SEL_W'(N_DIGITS - 1) - sel));
    case (state)
      PLAY:    glyph = digit_gly[sel];
      OVER:    glyph = blink_off ? GLY_BLANK : msg_glyph(OVER, 5'(sel), START_KEY);
      default: glyph = msg_glyph(MAIN, 5'(sel), START_KEY);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= MAIN;
      bus.is_main    <= 1'b1;
      bus.play_start <= 1'b0;
      bus.seg_com    <= '1;
      bus.seg_txt    <= '0;
      sel            <= '0;
      key_prev       <= '1;
      blink_cnt      <= '0;
      blink_off      <= 1'b0;
      to_cnt         <= '0;
    end else begin
      bus.play_start <= 1'b0;
      if (tick) begin
        key_prev    <= bus.key_data;
        bus.seg_com <= com_next;
        bus.seg_txt <= glyph;
        sel         <= (sel == SEL_W'(N_DIGITS - 1)) ? '0 : sel + 1'b1;
      end
      case (state)
        MAIN: if (press) begin
          state          <= PLAY;
          bus.is_main    <= 1'b0;
          bus.play_start <= 1'b1;
        end
        PLAY: if (bus.game_over) begin
          state     <= OVER;
          blink_cnt <= '0;
          blink_off <= 1'b0;
          to_cnt    <= '0;
        end
        OVER: begin
          if (press || timeout) begin
            state       <= MAIN;
            bus.is_main <= 1'b1;
          end else if (tick) begin
            to_cnt <= to_cnt + 1'b1;
            if (blink_cnt == BL_W'(BLINK_TICKS - 1)) begin
              blink_cnt <= '0;
              blink_off <= ~blink_off;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end
        default: state <= MAIN;
      endcase
    end
  end
endmodule

// File: tb/tb_menu_display_ctrl.sv
// Bench for menu_display_ctrl: table of MAIN scan/key vectors, then PLAY/OVER
// sequences; expectations go through a scoreboard queue, one entry per tick.
module tb_menu_display_ctrl;
  import menu_pkg::*;

  localparam int CLK_DIV     = 4;
  localparam int N_DIGITS    = 8;
  localparam int KEY_W       = 12;
  localparam int BLINK_TICKS = 2;
  localparam int OVER_TICKS  = 8;

  typedef struct {
    logic [11:0] key;
    logic [7:0]  com;
    logic [6:0]  txt;
    logic [6:0]  txt9;
    logic        main;
    logic        ps;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] com;
    logic [6:0] txt;
    logic [6:0] txt9;
    logic       main;
    logic       ps;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t exp_q [$];
  vec_t tab [13];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   phase = 0;
  int   sel_m = 0;

  logic [6:0] main0    [8] = '{7'h73, 7'h50, 7'h79, 7'h6D, 7'h6D, 7'h00, 7'h3F, 7'h06};
  logic [6:0] main9    [8] = '{7'h73, 7'h50, 7'h79, 7'h6D, 7'h6D, 7'h00, 7'h06, 7'h3F};
  logic [6:0] over_tab [8] = '{7'h79, 7'h54, 7'h5E, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  logic [6:0] play_tab [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

  always #5 clk = ~clk;

  menu_display_ctrl_if #(.N_DIGITS(N_DIGITS), .KEY_W(KEY_W)) bus ();
  menu_display_ctrl_if #(.N_DIGITS(N_DIGITS), .KEY_W(KEY_W)) bus9 ();

  menu_display_ctrl #(.CLK_DIV(CLK_DIV), .N_DIGITS(N_DIGITS), .KEY_W(KEY_W), .START_KEY(0),
                      .BLINK_TICKS(BLINK_TICKS), .OVER_TICKS(OVER_TICKS))
    dut (.clk(clk), .rst(rst), .bus(bus));

  menu_display_ctrl #(.CLK_DIV(CLK_DIV), .N_DIGITS(N_DIGITS), .KEY_W(KEY_W), .START_KEY(9),
                      .BLINK_TICKS(BLINK_TICKS), .OVER_TICKS(OVER_TICKS))
    dut9 (.clk(clk), .rst(rst), .bus(bus9));

  function automatic logic [7:0] exp_com(input int s);
    return ~(8'h80 >> s);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    @(negedge clk);
    phase = (phase + 1) % CLK_DIV;
  endtask

  task automatic step_tick();
    repeat (CLK_DIV - phase) @(posedge clk);
    @(negedge clk);
    phase = 0;
    sel_m = (sel_m + 1) % N_DIGITS;
  endtask

  // Expected values are queued for the digit about to be scanned, then one tick runs.
  task automatic applyStimulus(input string name, input logic [11:0] key, input logic [7:0] com,
                               input logic [6:0] txt, input logic [6:0] txt9,
                               input logic main, input logic ps);
    exp_t e;
    e.name = name; e.com = com; e.txt = txt; e.txt9 = txt9; e.main = main; e.ps = ps;
    bus.key_data = key;
    exp_q.push_back(e);
    step_tick();
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL scoreboard: queue empty, nothing to compare");
      return;
    end
    e = exp_q.pop_front();
    cmp({e.name, " seg_com"}, bus.seg_com, e.com);
    cmp({e.name, " seg_txt"}, bus.seg_txt, e.txt);
    cmp({e.name, " key9 seg_com"}, bus9.seg_com, e.com);
    cmp({e.name, " key9 seg_txt"}, bus9.seg_txt, e.txt9);
    cmp({e.name, " is_main"}, bus.is_main, e.main);
    cmp({e.name, " play_start"}, bus.play_start, e.ps);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tab[0]  = '{12'h001, 8'h7F, 7'h73, 7'h73, 1'b1, 1'b0};
    tab[1]  = '{12'h001, 8'hBF, 7'h50, 7'h50, 1'b1, 1'b0};
    tab[2]  = '{12'h001, 8'hDF, 7'h79, 7'h79, 1'b1, 1'b0};
    tab[3]  = '{12'h001, 8'hEF, 7'h6D, 7'h6D, 1'b1, 1'b0};
    tab[4]  = '{12'h001, 8'hF7, 7'h6D, 7'h6D, 1'b1, 1'b0};
    tab[5]  = '{12'h001, 8'hFB, 7'h00, 7'h00, 1'b1, 1'b0};
    tab[6]  = '{12'h001, 8'hFD, 7'h3F, 7'h06, 1'b1, 1'b0};
    tab[7]  = '{12'h001, 8'hFE, 7'h06, 7'h3F, 1'b1, 1'b0};
    tab[8]  = '{12'h000, 8'h7F, 7'h73, 7'h73, 1'b1, 1'b0};
    tab[9]  = '{12'h003, 8'hBF, 7'h50, 7'h50, 1'b1, 1'b0};
    tab[10] = '{12'h002, 8'hDF, 7'h79, 7'h79, 1'b1, 1'b0};
    tab[11] = '{12'h000, 8'hEF, 7'h6D, 7'h6D, 1'b1, 1'b0};
    tab[12] = '{12'h001, 8'hF7, 7'h6D, 7'h6D, 1'b0, 1'b1};

    rst = 1'b1;
    bus.key_data = 12'h001;
    bus.game_over = 1'b0;
    bus.disp_data = '0;
    bus9.key_data = '0;
    bus9.game_over = 1'b0;
    bus9.disp_data = '0;
    repeat (3) @(negedge clk);
    cmp("reset seg_com", bus.seg_com, 8'hFF);
    cmp("reset seg_txt", bus.seg_txt, 7'h00);
    cmp("reset is_main", bus.is_main, 1'b1);
    cmp("reset play_start", bus.play_start, 1'b0);
    rst = 1'b0;
    phase = 0;
    sel_m = 0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus($sformatf("row%0d", i), tab[i].key, tab[i].com, tab[i].txt,
                    tab[i].txt9, tab[i].main, tab[i].ps);
      checkOutput();
      if (i == 0) begin
        step_clk();
        cmp("hold seg_com", bus.seg_com, 8'h7F);
        cmp("hold seg_txt", bus.seg_txt, 7'h73);
      end
    end
    step_clk();
    cmp("pulse end play_start", bus.play_start, 1'b0);
    cmp("play is_main", bus.is_main, 1'b0);

    // PLAY: glyphs come from disp_data; keypad activity must not matter
    bus.disp_data = {7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
    for (int i = 0; i < 11; i++) begin
      applyStimulus($sformatf("play%0d", i), (i == 3) ? 12'h000 : 12'h001, exp_com(sel_m),
                    play_tab[sel_m], main9[sel_m], 1'b0, 1'b0);
      checkOutput();
    end

    bus.key_data = '0;
    bus.game_over = 1'b1;
    step_clk();
    bus.game_over = 1'b0;
    cmp("over entry is_main", bus.is_main, 1'b0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus($sformatf("over%0d", k), 12'h000, exp_com(sel_m),
                    ((k % 4) < 2) ? over_tab[sel_m] : 7'h00, main9[sel_m], k == 7, 1'b0);
      checkOutput();
    end

    // Second game: press lands on the same tick as the OVER timeout
    applyStimulus("rel2", 12'h000, exp_com(sel_m), main0[sel_m], main9[sel_m], 1'b1, 1'b0);
    checkOutput();
    applyStimulus("press2", 12'h001, exp_com(sel_m), main0[sel_m], main9[sel_m], 1'b0, 1'b1);
    checkOutput();
    bus.key_data = '0;
    bus.game_over = 1'b1;
    step_clk();
    bus.game_over = 1'b0;
    cmp("over2 play_start", bus.play_start, 1'b0);
    cmp("over2 is_main", bus.is_main, 1'b0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus($sformatf("over2_%0d", k), (k == 7) ? 12'h001 : 12'h000, exp_com(sel_m),
                    ((k % 4) < 2) ? over_tab[sel_m] : 7'h00, main9[sel_m], k == 7, 1'b0);
      checkOutput();
    end
    applyStimulus("held", 12'h001, exp_com(sel_m), main0[sel_m], main9[sel_m], 1'b1, 1'b0);
    checkOutput();
    step_clk();
    cmp("held play_start", bus.play_start, 1'b0);

    applyStimulus("rel3", 12'h000, exp_com(sel_m), main0[sel_m], main9[sel_m], 1'b1, 1'b0);
    checkOutput();
    applyStimulus("press3", 12'h001, exp_com(sel_m), main0[sel_m], main9[sel_m], 1'b0, 1'b1);
    checkOutput();
    rst = 1'b1;
    #1;
    cmp("midrst seg_com", bus.seg_com, 8'hFF);
    cmp("midrst seg_txt", bus.seg_txt, 7'h00);
    cmp("midrst is_main", bus.is_main, 1'b1);
    cmp("midrst play_start", bus.play_start, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
